// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: FSM states, request
// opcodes and the wait-counter width.
package mem_resp_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory port (master) and the
// memory responder (slave); separate read and write data paths.
interface mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              load;
    logic              store;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              err;
    logic              busy;

    modport master (
        output addr, load, store, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  addr, load, store, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/mem_resp_array.sv
// Single-port DEPTH x DATA_W storage with a registered read port;
// a write returns the new word on the read port (write-first).
module mem_resp_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd;

    // NOTE: the storage has no reset; clearing it would turn the array into
    // thousands of resettable flops instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wd;
            r_rd       <= wd;
        end else begin
            r_rd <= r_mem[idx];
        end
    end

    assign rd = r_rd;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one load/store at a time, waits WAIT_CYCLES
// in BUSY to model access time, then answers with a one-cycle ready pulse.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             r_state;
    op_t                r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_oor;
    logic               r_ready;
    logic               r_err;
    logic               r_busy;
    logic [DATA_W-1:0]  r_rdata;

    logic               w_accept;
    logic               w_req_oor;
    logic [IDX_W-1:0]   w_idx;
    logic               w_we;
    logic               w_rd_hit;
    logic [DATA_W-1:0]  w_arr_rd;

    assign w_accept  = (r_state == IDLE) && (bus.load || bus.store);
    assign w_req_oor = 32'(bus.addr) >= 32'(DEPTH);

    // The array read is registered, so in IDLE it already looks at the live
    // address; with zero wait the data must be ready on the accepting edge.
    assign w_idx    = (r_state == IDLE) ? bus.addr[IDX_W-1:0] : r_idx;
    assign w_we     = (r_state == RESP) && (r_op == OP_WR) && !r_oor && !rst;
    assign w_rd_hit = (r_state == RESP) && (r_op == OP_RD) && !r_oor;

    mem_resp_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk (clk),
        .we  (w_we),
        .idx (w_idx),
        .wd  (r_wdata),
        .rd  (w_arr_rd)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_RD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_oor   <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.store ? OP_WR : OP_RD;
                        r_idx   <= bus.addr[IDX_W-1:0];
                        r_wdata <= bus.wdata;
                        r_oor   <= w_req_oor;
                        r_cnt   <= CNT_W'(WAIT_CYCLES);
                        r_busy  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                            r_err   <= w_req_oor;
                            if (w_req_oor) r_rdata <= '0;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= RESP;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_err   <= r_oor;
                        if (r_oor) r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    // Capture the read word so rdata holds after the pulse.
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (w_rd_hit) r_rdata <= w_arr_rd;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata = w_rd_hit ? w_arr_rd : r_rdata;
    assign bus.ready = r_ready;
    assign bus.err   = r_err;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_CYCLES=3 (slot 1)
// and one with WAIT_CYCLES=0 (slot 0), sharing clock and reset.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    logic [15:0] t_addr  [2];
    logic [15:0] t_wdata [2];
    logic [1:0]  t_load;
    logic [1:0]  t_store;
    logic [15:0] o_rdata [2];
    logic [1:0]  o_ready;
    logic [1:0]  o_err;
    logic [1:0]  o_busy;

    assign bus0.addr  = t_addr[0];
    assign bus0.wdata = t_wdata[0];
    assign bus0.load  = t_load[0];
    assign bus0.store = t_store[0];
    assign bus3.addr  = t_addr[1];
    assign bus3.wdata = t_wdata[1];
    assign bus3.load  = t_load[1];
    assign bus3.store = t_store[1];
    assign o_rdata[0] = bus0.rdata;
    assign o_rdata[1] = bus3.rdata;
    assign o_ready    = {bus3.ready, bus0.ready};
    assign o_err      = {bus3.err, bus0.err};
    assign o_busy     = {bus3.busy, bus0.busy};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a request for one cycle and wait for ready. lat counts edges from
    // the presentation cycle to the first sample showing ready (WAIT_CYCLES+1),
    // or stays -1 if ready never arrives.
    task automatic req(input int s, input logic ld, input logic st,
                       input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output logic er, output int lat);
        @(posedge clk); #1;
        t_load[s]  = ld;
        t_store[s] = st;
        t_addr[s]  = a;
        t_wdata[s] = d;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            t_load[s]  = 1'b0;
            t_store[s] = 1'b0;
            if (o_ready[s]) begin
                lat = i;
                rd  = o_rdata[s];
                er  = o_err[s];
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;
        int          pulses;
        int          k;
        logic [15:0] z_exp [3];

        z_exp = '{16'h1000, 16'h2001, 16'h3002};
        t_addr  = '{16'h0, 16'h0};
        t_wdata = '{16'h0, 16'h0};
        t_load  = '0;
        t_store = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'h0);
        check("rst_err",   32'(o_err),   32'h0);
        check("rst_busy",  32'(o_busy),  32'h0);
        check("rst_rdata", 32'(o_rdata[1]), 32'h0);
        rst = 1'b0;

        // 1. reset during a pending store
        req(1, 1'b0, 1'b1, 16'h0020, 16'h0BEE, rd, er, lat);
        check("t1_pre_wr_lat", 32'(lat), 32'd4);
        req(1, 1'b1, 1'b0, 16'h0020, 16'h0000, rd, er, lat);
        check("t1_pre_rd", 32'(rd), 32'h0BEE);
        @(posedge clk); #1;
        t_store[1] = 1'b1;
        t_addr[1]  = 16'h0020;
        t_wdata[1] = 16'hDEAD;
        @(posedge clk); #1;
        t_store[1] = 1'b0;
        check("t1_busy_before_rst", 32'(o_busy[1]), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t1_ready_after_rst", 32'(o_ready[1]), 32'h0);
        check("t1_err_after_rst",   32'(o_err[1]),   32'h0);
        check("t1_busy_after_rst",  32'(o_busy[1]),  32'h0);
        check("t1_rdata_after_rst", 32'(o_rdata[1]), 32'h0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (o_ready[1]) pulses++;
        end
        check("t1_no_ready_pulse", 32'(pulses), 32'h0);
        req(1, 1'b1, 1'b0, 16'h0020, 16'h0000, rd, er, lat);
        check("t1_read_prior", 32'(rd), 32'h0BEE);

        // 2. basic write then read, WAIT_CYCLES=3
        req(1, 1'b0, 1'b1, 16'h0010, 16'hA5C3, rd, er, lat);
        check("t2_wr_lat", 32'(lat), 32'd4);
        check("t2_wr_err", 32'(er), 32'h0);
        req(1, 1'b1, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
        check("t2_rd_lat",   32'(lat), 32'd4);
        check("t2_rd_data",  32'(rd),  32'hA5C3);
        check("t2_rd_err",   32'(er),  32'h0);

        // 3. zero wait: fill words 0..2, then stream loads
        for (int i = 0; i < 3; i++) begin
            req(0, 1'b0, 1'b1, 16'(i), z_exp[i], rd, er, lat);
            check("t3_wr_lat", 32'(lat), 32'd1);
        end
        @(posedge clk); #1;
        k = 0;
        t_addr[0] = 16'h0000;
        t_load[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("t3_ready_pattern", 32'(o_ready[0]), 32'((i % 2) == 0));
            if (o_ready[0] && k < 3) begin
                check("t3_stream_rdata", 32'(o_rdata[0]), 32'(z_exp[k]));
                k++;
                t_addr[0] = 16'(k);
            end
        end
        t_load[0] = 1'b0;
        check("t3_stream_count", 32'(k), 32'd3);

        // 4. out of range
        req(1, 1'b0, 1'b1, 16'h0000, 16'h5555, rd, er, lat);
        check("t4_wr0_err", 32'(er), 32'h0);
        req(1, 1'b0, 1'b1, 16'h0100, 16'h1234, rd, er, lat);
        check("t4_oor_wr_err", 32'(er), 32'h1);
        check("t4_oor_wr_lat", 32'(lat), 32'd4);
        req(1, 1'b1, 1'b0, 16'h0100, 16'h0000, rd, er, lat);
        check("t4_oor_rd_err",  32'(er), 32'h1);
        check("t4_oor_rd_data", 32'(rd), 32'h0);
        req(1, 1'b1, 1'b0, 16'h0000, 16'h0000, rd, er, lat);
        check("t4_addr0_kept", 32'(rd), 32'h5555);
        check("t4_addr0_err",  32'(er), 32'h0);

        // 5. load and store together act as a store
        req(1, 1'b1, 1'b1, 16'h0005, 16'h0F0F, rd, er, lat);
        check("t5_both_err", 32'(er), 32'h0);
        check("t5_both_rdata_held", 32'(rd), 32'h5555);
        req(1, 1'b1, 1'b0, 16'h0005, 16'h0000, rd, er, lat);
        check("t5_rd_data", 32'(rd), 32'h0F0F);

        // 6. inputs changing during BUSY are ignored
        req(1, 1'b0, 1'b1, 16'h0008, 16'h8888, rd, er, lat);
        @(posedge clk); #1;
        t_store[1] = 1'b1;
        t_addr[1]  = 16'h0007;
        t_wdata[1] = 16'h1111;
        @(posedge clk); #1;
        t_addr[1]  = 16'h0008;
        t_wdata[1] = 16'h2222;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (o_ready[1]) begin
                pulses++;
                t_store[1] = 1'b0;
                break;
            end
        end
        check("t6_ready_seen", 32'(pulses), 32'h1);
        req(1, 1'b1, 1'b0, 16'h0007, 16'h0000, rd, er, lat);
        check("t6_rd7", 32'(rd), 32'h1111);
        req(1, 1'b1, 1'b0, 16'h0008, 16'h0000, rd, er, lat);
        check("t6_rd8", 32'(rd), 32'h8888);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
